// File: rtl/conv_buf_pkg.sv
// Shared definitions for the column-buffer burst controller:
// FSM state encoding and a counter-width helper.
package conv_buf_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BURST = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   // clog2 with a floor of one bit, so degenerate parameters (1 or 2)
   // still produce a legal vector width.
   function automatic int unsigned cb_width(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rd_lat_pipe.sv
// Delay line that carries the FIFO read strobe forward by LAT cycles so the
// shift-register enable lines up with the FIFO's read data. LAT=0 is a wire.
module rd_lat_pipe #(
   parameter int unsigned LAT = 1
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_d,
   output logic o_q
);

   if (LAT == 0) begin : g_pass
      // Clock and reset have no job in the passthrough build.
      logic w_unused;
      assign w_unused = ^{i_clk, i_rst};
      assign o_q      = i_d;
   end else if (LAT == 1) begin : g_one
      logic r_q;
      // Single register stage, cleared by reset.
      always_ff @(posedge i_clk) begin
         if (i_rst) r_q <= 1'b0;
         else       r_q <= i_d;
      end
      assign o_q = r_q;
   end else begin : g_many
      logic [LAT-1:0] r_pipe;
      // Shift register; the oldest sample leaves from the top bit.
      always_ff @(posedge i_clk) begin
         if (i_rst) r_pipe <= '0;
         else       r_pipe <= {r_pipe[LAT-2:0], i_d};
      end
      assign o_q = r_pipe[LAT-1];
   end

endmodule

// File: rtl/col_buff_burst_ctrl.sv
// Column-buffer burst controller. Waits for enough pixels in the FIFO,
// reads one column (ROW pixels) per burst, produces the shift-register
// enable at the FIFO's read latency and tracks column/window progress.
module col_buff_burst_ctrl
   import conv_buf_pkg::*;
#(
   parameter int unsigned ROW          = 9,
   parameter int unsigned COL          = 3,
   parameter int unsigned W_ADDR       = 8,
   parameter int unsigned FIRST_THRESH = ROW * COL + 1,
   parameter int unsigned NEXT_THRESH  = ROW,
   parameter int unsigned RD_LAT       = 1
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_en,
   input  logic                     i_frame_start,
   input  logic                     i_fifo_empty,
   input  logic [W_ADDR:0]          occupants,
   input  logic                     i_stall,
   output logic                     o_read_enable,
   output logic                     sr_enable,
   output logic [cb_width(COL)-1:0] o_col_idx,
   output logic                     o_busy,
   output logic                     o_window_valid,
   output logic                     o_done
);

   localparam int unsigned W_OCC = W_ADDR + 1;
   localparam int unsigned W_ROW = cb_width(ROW + 1);
   localparam int unsigned W_COL = cb_width(COL);
   localparam int unsigned W_CNT = cb_width(COL + 1);

   localparam logic [W_OCC-1:0] FIRST_T  = W_OCC'(FIRST_THRESH);
   localparam logic [W_OCC-1:0] NEXT_T   = W_OCC'(NEXT_THRESH);
   localparam logic [W_ROW-1:0] ROW_L    = W_ROW'(ROW);
   localparam logic [W_ROW-1:0] ROW_LAST = W_ROW'(ROW - 1);
   localparam logic [W_COL-1:0] COL_LAST = W_COL'(COL - 1);
   localparam logic [W_CNT-1:0] COL_FULL = W_CNT'(COL);

   state_t           r_state;
   state_t           w_next;
   logic [W_ROW-1:0] r_row_cnt;
   logic [W_COL-1:0] r_col_idx;
   logic [W_CNT-1:0] r_cols_loaded;
   logic             r_first;
   logic             r_fs_pend;
   logic             r_done;
   logic             r_window;

   logic             w_rd;
   logic [W_OCC-1:0] w_thresh;
   logic             w_fs_any;
   logic [W_COL-1:0] w_col_nxt;
   logic [W_CNT-1:0] w_loaded_nxt;

   // The first burst of a frame must see a full window plus one pixel.
   assign w_thresh     = r_first ? FIRST_T : NEXT_T;
   assign w_fs_any     = r_fs_pend | i_frame_start;
   assign w_col_nxt    = (r_col_idx == COL_LAST) ? '0 : r_col_idx + 1'b1;
   assign w_loaded_nxt = (r_cols_loaded == COL_FULL) ? COL_FULL
                                                     : r_cols_loaded + 1'b1;

   // State register; reset wins over everything, including a live burst.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= ST_IDLE;
      else       r_state <= w_next;
   end

   // Next-state and read-strobe decode. The read is combinational so it
   // issues in the same cycle the FIFO shows data and no back-pressure.
   // NOTE: every output of this block is defaulted first so no path leaves
   // a value unassigned, which would otherwise infer a latch.
   always_comb begin
      w_next = r_state;
      w_rd   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_en && !i_fifo_empty && (occupants >= w_thresh))
               w_next = ST_BURST;
         end
         ST_BURST: begin
            w_rd = !i_fifo_empty && !i_stall && (r_row_cnt < ROW_L);
            if (w_rd && (r_row_cnt == ROW_LAST))
               w_next = ST_DRAIN;
         end
         ST_DRAIN: begin
            // Covers the single cycle of read latency; with RD_LAT=0 it
            // is simply one quiet cycle before bookkeeping.
            w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // Burst bookkeeping: row count, column index, window fill, frame restart.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_row_cnt     <= '0;
         r_col_idx     <= '0;
         r_cols_loaded <= '0;
         r_first       <= 1'b1;
         r_fs_pend     <= 1'b0;
         r_done        <= 1'b0;
         r_window      <= 1'b0;
      end else begin
         r_done   <= 1'b0;
         r_window <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (i_frame_start) begin
                  r_col_idx     <= '0;
                  r_cols_loaded <= '0;
                  r_first       <= 1'b1;
               end
            end
            ST_BURST: begin
               // A frame start mid-burst waits until the burst retires.
               if (i_frame_start) r_fs_pend <= 1'b1;
               if (w_rd) begin
                  r_row_cnt <= r_row_cnt + 1'b1;
                  r_first   <= 1'b0;
               end
            end
            ST_DRAIN: begin
               r_done    <= 1'b1;
               r_row_cnt <= '0;
               r_fs_pend <= 1'b0;
               if (w_fs_any) begin
                  // Restarting the frame discards this burst's column and
                  // suppresses its window pulse.
                  r_col_idx     <= '0;
                  r_cols_loaded <= '0;
                  r_first       <= 1'b1;
               end else begin
                  r_col_idx     <= w_col_nxt;
                  r_cols_loaded <= w_loaded_nxt;
                  r_window      <= (w_loaded_nxt == COL_FULL);
               end
            end
            default: ;
         endcase
      end
   end

   rd_lat_pipe #(
      .LAT (RD_LAT)
   ) u_rd_lat_pipe (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_d   (w_rd),
      .o_q   (sr_enable)
   );

   assign o_read_enable  = w_rd;
   assign o_busy         = (r_state != ST_IDLE);
   assign o_col_idx      = r_col_idx;
   assign o_done         = r_done;
   assign o_window_valid = r_window;

endmodule

// File: doc/col_buff_burst_ctrl.md
Name: col_buff_burst_ctrl

Overview:
Parametrised successor to the column-buffer read controller. It watches FIFO occupancy and issues gated bursts of ROW reads, one burst per image column. Each FIFO read produces a shift-register enable aligned to the FIFO's read latency. It tracks the column index and flags when a full COL-wide window has been shifted in. It sits between the pixel FIFO and the convolution column shift registers.

Parameters:
ROW, 9, reads per burst (pixels per column); must be at least 1
COL, 3, columns per window; must be at least 1
W_ADDR, 8, FIFO address width; occupancy bus is W_ADDR+1 bits
FIRST_THRESH, ROW*COL+1, occupancy required before the first burst of a frame
NEXT_THRESH, ROW, occupancy required before every later burst
RD_LAT, 1, FIFO read-data latency in cycles; legal values 0 or 1

Ports:
i_clk  in  1  clock; all logic on the rising edge
i_rst  in  1  synchronous, active-high reset
i_en  in  1  allows new bursts to start; dropping it never aborts a burst in progress
i_frame_start  in  1  single-cycle pulse; clears the column and window tracking
i_fifo_empty  in  1  FIFO empty flag
occupants  in  W_ADDR+1  FIFO occupancy count
i_stall  in  1  downstream back-pressure; holds reads off while high
o_read_enable  out  1  FIFO read strobe
sr_enable  out  1  column shift-register enable
o_col_idx  out  clog2(COL), minimum 1  index of the column currently being loaded
o_busy  out  1  high in BURST and DRAIN
o_window_valid  out  1  one-cycle pulse: a complete window is present
o_done  out  1  one-cycle pulse at the end of each burst

Behaviour:
- Reset: on i_rst, all outputs go to 0 on the next edge. Clears row counter, column counter, columns-loaded counter, first-burst flag (set to 1) and the RD_LAT pipe. Reset takes priority over every other input, including mid-burst.
- FSM states: IDLE, BURST, DRAIN.
- IDLE -> BURST when all hold:
  - i_en is 1 and i_fifo_empty is 0
  - occupants >= FIRST_THRESH if the first-burst flag is set, otherwise occupants >= NEXT_THRESH
  - Compare at full W_ADDR+1 width (unsigned).
- BURST:
  - o_read_enable = (state==BURST) & !i_fifo_empty & !i_stall & (row_cnt < ROW). This is combinational, so the read issues in the same cycle the FIFO is non-empty.
  - row_cnt increments only on an actual read.
  - Empty or stall mid-burst pauses reads with no loss and no over-read.
  - On the cycle the ROW-th read issues, go to DRAIN.
  - Clear the first-burst flag on the first read.
- sr_enable:
  - RD_LAT=0: sr_enable = o_read_enable.
  - RD_LAT=1: sr_enable is o_read_enable registered one cycle.
  - There are exactly ROW sr_enable pulses per burst.
- DRAIN:
  - Lasts RD_LAT cycles; with RD_LAT=0, DRAIN is one cycle with no reads.
  - On exit to IDLE:
    - o_done pulses for one cycle.
    - row_cnt returns to 0.
    - o_col_idx advances, wrapping from COL-1 to 0.
    - cols_loaded saturates at COL.
    - If cols_loaded >= COL after the increment, o_window_valid pulses together with o_done.
  - From IDLE, a back-to-back burst can begin the next cycle.
- i_frame_start:
  - In IDLE: clears o_col_idx and cols_loaded and sets the first-burst flag.
  - In BURST or DRAIN: latched and applied at the DRAIN->IDLE transition, after that burst's bookkeeping. The o_window_valid pulse for that burst is suppressed.
- Simultaneous empty and stall: no read. Occupancy dropping below threshold mid-burst is ignored; only empty and stall gate reads.
- Widths:
  - row_cnt is clog2(ROW+1) bits.
  - cols_loaded is clog2(COL+1) bits.
  - ROW must not exceed 2**W_ADDR.

Decomposition:
- Shared package (conv_buf_pkg): state encoding enum (IDLE, BURST, DRAIN) and a width helper.
- Sub-module rd_lat_pipe: parametrised delay line of RD_LAT stages (0 = passthrough) carrying the read strobe to sr_enable, with synchronous reset.

Test Plan:
- Reset and threshold (defaults, RD_LAT=1):
  - Hold occupants=27, not empty -> no reads.
  - Set occupants=28 -> BURST next edge; 9 consecutive o_read_enable cycles.
  - sr_enable trails by 1 cycle.
  - o_done after the last sr_enable.
  - o_col_idx 0->1.
- Window fill:
  - Three bursts (first at 28, then at >=9) -> o_window_valid pulses only on burst 3's o_done, and o_col_idx wraps 2->0.
  - A fourth burst pulses it again.
- Empty and stall mid-burst:
  - Assert i_fifo_empty after read 4 for 3 cycles, then i_stall for 2 cycles.
  - Exactly 9 reads total, none while empty or stalled, count resumes at 5.
- Reset mid-burst:
  - i_rst at read 6 -> all outputs 0 next cycle.
  - Next burst requires occupants >= 28 again and delivers 9 full reads.
- i_en and frame_start:
  - Drop i_en at read 3 -> burst completes all 9 reads, no new burst starts.
  - Pulse i_frame_start during a burst -> after o_done, o_col_idx=0 and the next start needs 28.
- RD_LAT=0 build:
  - sr_enable is identical to o_read_enable cycle by cycle.
  - DRAIN lasts one cycle.
